// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Opcode/state types and op-class helpers for muldiv_unit.
//               MULDIV_MACC_EN adds the MADD/MSUB family to the multiply class.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MADD  = 4'd7,
        MD_MADDU = 4'd8,
        MD_MSUB  = 4'd9,
        MD_MSUBU = 4'd10
    } md_op_e;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_mul(input logic [3:0] op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MULDIV_MACC_EN
        r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
        return r;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_core
// Description : Combinational {hi,lo} result for one multiply/divide op.
//               MULDIV_MACC_EN enables the accumulate/subtract opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int c_w2 = 2 * WIDTH;

    logic [c_w2-1:0]  w_a_sx, w_b_sx, w_a_zx, w_b_zx;
    logic [c_w2-1:0]  w_prod_s, w_prod_u, w_acc;
    logic             w_sgn, w_neg_a, w_neg_b, w_b_zero;
    logic [WIDTH-1:0] w_mag_a, w_mag_b, w_dvs, w_q, w_r, w_quo, w_rem;

    // Sign extension to 2W keeps the truncated product correct for signed ops.
    assign w_a_sx   = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_b_sx   = {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_a_zx   = {{WIDTH{1'b0}}, i_a};
    assign w_b_zx   = {{WIDTH{1'b0}}, i_b};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = w_a_zx * w_b_zx;
    assign w_acc    = {i_hi, i_lo};

    // Magnitude division; the -2^(W-1)/-1 case falls out as lo=a, hi=0.
    assign w_sgn    = (i_op == MD_DIV);
    assign w_neg_a  = w_sgn & i_a[WIDTH-1];
    assign w_neg_b  = w_sgn & i_b[WIDTH-1];
    assign w_mag_a  = w_neg_a ? -i_a : i_a;
    assign w_mag_b  = w_neg_b ? -i_b : i_b;
    assign w_b_zero = (i_b == '0);
    assign w_dvs    = w_b_zero ? WIDTH'(1) : w_mag_b;
    assign w_q      = w_mag_a / w_dvs;
    assign w_r      = w_mag_a % w_dvs;
    assign w_quo    = (w_neg_a ^ w_neg_b) ? -w_q : w_q;
    assign w_rem    = w_neg_a ? -w_r : w_r;

    always_comb begin
        {o_hi, o_lo} = w_acc;
        case (i_op)
            MD_MULT:  {o_hi, o_lo} = w_prod_s;
            MD_MULTU: {o_hi, o_lo} = w_prod_u;
            MD_DIV, MD_DIVU: begin
                if (w_b_zero) {o_hi, o_lo} = {i_a, {WIDTH{1'b1}}};
                else          {o_hi, o_lo} = {w_rem, w_quo};
            end
`ifdef MULDIV_MACC_EN
            MD_MADD:  {o_hi, o_lo} = w_acc + w_prod_s;
            MD_MADDU: {o_hi, o_lo} = w_acc + w_prod_u;
            MD_MSUB:  {o_hi, o_lo} = w_acc - w_prod_s;
            MD_MSUBU: {o_hi, o_lo} = w_acc - w_prod_u;
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : E-stage multiply/divide unit with HI/LO, latency counter,
//               cancel and done pulse. MULDIV_MACC_EN enables MADD/MSUB ops.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_max_lat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_cnt_w   = $clog2(c_max_lat + 1);
    localparam logic [c_cnt_w-1:0] c_mul_cnt = c_cnt_w'(MUL_LAT);
    localparam logic [c_cnt_w-1:0] c_div_cnt = c_cnt_w'(DIV_LAT);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

    md_state_e          r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_hi, r_lo, r_res_hi, r_res_lo, w_core_hi, w_core_lo;
    logic               r_done, w_accept, w_is_mul, w_start, w_last;

    assign w_is_mul = is_mul(op);
    assign w_accept = op_valid & (r_state == MD_IDLE) & ~cancel;
    assign w_start  = w_accept & (w_is_mul | is_div(op));
    assign w_last   = (r_state == MD_RUN) & (r_count == c_one) & ~cancel;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .i_op (op),
        .i_a  (a),
        .i_b  (b),
        .i_hi (r_hi),
        .i_lo (r_lo),
        .o_hi (w_core_hi),
        .o_lo (w_core_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= MD_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (w_start) w_state_nxt = MD_RUN;
            MD_RUN:  if (cancel || r_count == c_one) w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    // Result is captured at accept so forwarded operands may change while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                r_res_hi <= w_core_hi;
                r_res_lo <= w_core_lo;
                r_count  <= w_is_mul ? c_mul_cnt : c_div_cnt;
            end else if (r_state == MD_RUN) begin
                r_count <= cancel ? '0 : r_count - c_one;
                if (w_last) begin
                    r_hi   <= r_res_hi;
                    r_lo   <= r_res_lo;
                    r_done <= 1'b1;
                end
            end
            if (w_accept && op == MD_MTHI) r_hi <= a;
            if (w_accept && op == MD_MTLO) r_lo <= a;
        end
    end

    assign start = w_start;
    assign busy  = (r_state == MD_RUN);
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Scoreboard bench for muldiv_unit (WIDTH=32, MUL_LAT=5, DIV_LAT=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk, reset, op_valid, cancel;
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        start, busy, done;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    muldiv_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .a(a), .b(b),
        .cancel(cancel), .start(start), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Presents one op for one cycle and checks the combinational start.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic exp_start);
        @(negedge clk);
        op_valid = 1'b1; op = o; a = x; b = y;
        #1 chk("start", {63'd0, start}, {63'd0, exp_start});
        @(posedge clk);
        #1 op_valid = 1'b0; op = MD_NOP;
    endtask

    task automatic wait_done(input string nm, input int exp_busy);
        int nb;
        bit seen;
        nb = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            else if (busy) nb++;
        end
        chk({nm, "_done_seen"}, {63'd0, seen}, 64'd1);
        chk({nm, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (!reset && done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done actual=%h required=no_done", {hi, lo});
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                if ({hi, lo} !== e) begin
                    errors++;
                    $display("FAIL result actual=%h required=%h", {hi, lo}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_busy;
        reset = 1'b1; op_valid = 1'b0; op = MD_NOP; a = '0; b = '0; cancel = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
        reset = 1'b0;

        sb.push_back(64'hFFFFFFFF_FFFFFFEB);
        issue(MD_MULT, 32'hFFFFFFFD, 32'd7, 1'b1);
        wait_done("mult", 5);

        sb.push_back({32'd2, 32'd14});
        issue(MD_DIVU, 32'd100, 32'd7, 1'b1);
        wait_done("divu", 10);

        sb.push_back(64'hFFFFFFFF_FFFFFFFD);
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_done("div_neg", 10);

        sb.push_back({32'd5, 32'hFFFFFFFF});
        issue(MD_DIV, 32'd5, 32'd0, 1'b1);
        wait_done("div_zero", 10);

        sb.push_back({32'd9, 32'hFFFFFFFF});
        issue(MD_DIVU, 32'd9, 32'd0, 1'b1);
        wait_done("divu_zero", 10);

        sb.push_back(64'hFFFFFFFE_00000001);
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_done("multu_max", 5);

        sb.push_back({32'd0, 32'h80000000});
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        wait_done("div_ovf", 10);

        issue(MD_MTHI, 32'h1234, 32'd0, 1'b0);
        @(negedge clk);
        chk("mthi", {hi, lo}, {32'h1234, 32'h80000000});

        // Ops presented while busy must be ignored.
        sb.push_back({32'd0, 32'd6});
        issue(MD_MULT, 32'd2, 32'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op_valid = 1'b1; op = MD_MTLO; a = 32'hDEAD;
            #1 chk("start_while_busy", {63'd0, start}, 64'd0);
        end
        @(posedge clk);
        #1 op_valid = 1'b0; op = MD_NOP;
        wait_done("mult_busy_ign", 2);
        @(negedge clk);
        chk("lo_after_ignored_mtlo", {hi, lo}, {32'd0, 32'd6});

        issue(MD_MULT, 32'd9, 32'd9, 1'b1);
        repeat (3) @(negedge clk);
        cancel = 1'b1;
        chk("busy_before_cancel", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        chk("busy_after_cancel", {63'd0, busy}, 64'd0);
        repeat (8) @(negedge clk);
        chk("hilo_after_cancel", {hi, lo}, {32'd0, 32'd6});

        issue(MD_DIV, 32'd100, 32'd3, 1'b1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("async_reset_busy", {62'd0, busy, done}, 64'd0);
        chk("async_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        issue(MD_MTLO, 32'h55, 32'd0, 1'b0);
        @(negedge clk);
        chk("mtlo", {hi, lo}, {32'd0, 32'h55});
        @(negedge clk);
        op_valid = 1'b1; op = MD_MTLO; a = 32'h77; cancel = 1'b1;
        #1 chk("start_cancel_mtlo", {63'd0, start}, 64'd0);
        @(posedge clk);
        #1 op_valid = 1'b0; op = MD_NOP; cancel = 1'b0;
        @(negedge clk);
        chk("lo_after_cancel_mtlo", {hi, lo}, {32'd0, 32'h55});

        issue(MD_MTHI, 32'd0, 32'd0, 1'b0);
        issue(MD_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
`ifdef MULDIV_MACC_EN
        sb.push_back({32'd1, 32'd0});
        issue(MD_MADDU, 32'd1, 32'd1, 1'b1);
        wait_done("maddu", 5);
`else
        issue(MD_MADDU, 32'd1, 32'd1, 1'b0);
        saw_busy = 0;
        repeat (7) begin
            @(negedge clk);
            if (busy) saw_busy = 1;
        end
        chk("maddu_disabled_busy", {63'd0, saw_busy}, 64'd0);
        chk("maddu_disabled_hilo", {hi, lo}, {32'd0, 32'hFFFFFFFF});
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
